// File: rtl/tdm_ser_tx.sv
//------------------------------------------------------------------------------
// tdm_ser_tx
//
// Parallel-to-serial TDM channel transmitter. Words arrive on a valid/ready
// stream, wait in a small FIFO, and are shifted out MSB-first as a
// bit clock / frame sync / serial data triplet. One word is sent per
// timeslot and CHANNELS timeslots make a frame, with no gap between frames.
// When the FIFO is empty at a word boundary, IDLE_WORD is sent instead.
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-low reset
//   enable       transmitter run; low holds the serial interface idle
//   in_data      word to transmit, consumed in timeslot order
//   in_valid     in_data valid
//   in_ready     FIFO can accept (combinational, = !full)
//   ser_d        serial data, MSB first
//   ser_clk      generated bit clock (data launched on its rising edge)
//   ser_fs       frame sync, high for bit 0 of timeslot 0
//   frame_start  one-clk pulse when timeslot 0 bit 0 is launched
//   underrun     one-clk pulse when IDLE_WORD is substituted
//   cur_chan     timeslot currently on ser_d
//   fifo_level   words held in the FIFO
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module tdm_ser_tx #(
    parameter int                CHANNELS   = 32,
    parameter int                WORD_W     = 8,
    parameter int                CLK_DIV    = 4,
    parameter int                FIFO_DEPTH = 4,
    parameter logic [WORD_W-1:0] IDLE_WORD  = 8'hD5
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic [WORD_W-1:0]             in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic                          ser_d,
    output logic                          ser_clk,
    output logic                          ser_fs,
    output logic                          frame_start,
    output logic                          underrun,
    output logic [$clog2(CHANNELS)-1:0]   cur_chan,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W  = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam int CHAN_W = $clog2(CHANNELS);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int LVL_W  = PTR_W + 1;

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WORD_W - 1);
    localparam logic [CHAN_W-1:0] CHAN_LAST = CHAN_W'(CHANNELS - 1);
    localparam logic [LVL_W-1:0]  LVL_FULL  = LVL_W'(FIFO_DEPTH);

    // FIFO storage and pointers
    logic [WORD_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;

    // Serializer state
    logic [DIV_W-1:0]  div_cnt;
    logic [BIT_W-1:0]  bit_idx;
    logic [CHAN_W-1:0] chan;
    logic [WORD_W-1:0] shift_reg;

    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    logic              tx_edge;
    logic              word_load;
    logic [WORD_W-1:0] load_word;

    assign fifo_full  = (fifo_level == LVL_FULL);
    assign fifo_empty = (fifo_level == '0);
    assign in_ready   = !fifo_full;

    // A full FIFO refuses the push even if a word is popped in the same
    // cycle, so in_ready never depends on the serializer timing.
    assign push = in_valid && !fifo_full;

    // A tx edge is the cycle in which ser_clk is about to toggle 0->1.
    assign tx_edge   = enable && (div_cnt == DIV_LAST) && !ser_clk;
    assign word_load = tx_edge && (bit_idx == '0);

    // An empty FIFO at a word load is an underrun; a word pushed in that
    // same cycle stays in the FIFO for the next slot.
    assign pop       = word_load && !fifo_empty;
    assign load_word = fifo_empty ? IDLE_WORD : fifo_mem[rd_ptr];

    // FIFO data array: written on every accepted push, never reset.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= in_data;
        end
    end

    // FIFO pointers and level. Power-of-two depth lets the pointers wrap
    // naturally. Disabling the transmitter leaves the FIFO untouched.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    // Bit-clock divider and serializer. Data, frame sync and the channel
    // number are all launched in the cycle ser_clk rises so that the far
    // end can sample them on the falling edge. Dropping enable abandons
    // the current word and restarts the next run at timeslot 0, bit 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt     <= '0;
            bit_idx     <= '0;
            chan        <= '0;
            shift_reg   <= '0;
            ser_clk     <= 1'b0;
            ser_d       <= 1'b0;
            ser_fs      <= 1'b0;
            frame_start <= 1'b0;
            underrun    <= 1'b0;
            cur_chan    <= '0;
        end else if (!enable) begin
            div_cnt     <= '0;
            bit_idx     <= '0;
            chan        <= '0;
            ser_clk     <= 1'b0;
            ser_d       <= 1'b0;
            ser_fs      <= 1'b0;
            frame_start <= 1'b0;
            underrun    <= 1'b0;
            cur_chan    <= '0;
        end else begin
            frame_start <= 1'b0;
            underrun    <= 1'b0;

            if (div_cnt == DIV_LAST) begin
                div_cnt <= '0;
                ser_clk <= !ser_clk;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end

            if (tx_edge) begin
                if (word_load) begin
                    ser_d       <= load_word[WORD_W-1];
                    shift_reg   <= load_word << 1;
                    ser_fs      <= (chan == '0);
                    frame_start <= (chan == '0);
                    underrun    <= fifo_empty;
                    cur_chan    <= chan;
                end else begin
                    ser_d     <= shift_reg[WORD_W-1];
                    shift_reg <= shift_reg << 1;
                    ser_fs    <= 1'b0;
                end

                if (bit_idx == BIT_LAST) begin
                    bit_idx <= '0;
                    chan    <= (chan == CHAN_LAST) ? '0 : chan + 1'b1;
                end else begin
                    bit_idx <= bit_idx + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_tdm_ser_tx.sv
//------------------------------------------------------------------------------
// tb_tdm_ser_tx
//
// Directed bench for tdm_ser_tx with CHANNELS=2, CLK_DIV=2 (32 clks per
// slot, 64 clks per frame). Words handed to the DUT are pushed onto an
// expected-word queue; each word-load pops the queue (or expects IDLE_WORD
// with an underrun when it is empty) and the serial bits are compared as
// they appear on ser_d. Outputs are sampled on the falling clock edge.
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_tdm_ser_tx;

    localparam int         CHANNELS   = 2;
    localparam int         WORD_W     = 8;
    localparam int         CLK_DIV    = 2;
    localparam int         FIFO_DEPTH = 4;
    localparam logic [7:0] IDLE_WORD  = 8'hD5;
    localparam int         RISE_LIMIT = 64;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       ser_d;
    logic       ser_clk;
    logic       ser_fs;
    logic       frame_start;
    logic       underrun;
    logic [0:0] cur_chan;
    logic [2:0] fifo_level;

    int         vectors     = 0;
    int         miscompares = 0;
    logic [7:0] exp_q[$];
    int         exp_chan;
    logic       prev_clk;
    bit         rise_pending;
    int         ticks_since_rise;
    int         fs_cnt;

    tdm_ser_tx #(
        .CHANNELS  (CHANNELS),
        .WORD_W    (WORD_W),
        .CLK_DIV   (CLK_DIV),
        .FIFO_DEPTH(FIFO_DEPTH),
        .IDLE_WORD (IDLE_WORD)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ser_d      (ser_d),
        .ser_clk    (ser_clk),
        .ser_fs     (ser_fs),
        .frame_start(frame_start),
        .underrun   (underrun),
        .cur_chan   (cur_chan),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Advance to the next falling edge and note any ser_clk rise.
    task automatic tick();
        @(negedge clk);
        ticks_since_rise++;
        if (ser_fs === 1'b1) fs_cnt++;
        if (ser_clk === 1'b1 && prev_clk === 1'b0) rise_pending = 1'b1;
        prev_clk = ser_clk;
    endtask

    task automatic wait_rise(input int gap);
        int n;
        n = 0;
        while (!rise_pending && n < RISE_LIMIT) begin
            tick();
            n++;
        end
        if (!rise_pending) begin
            vectors++;
            miscompares++;
            $error("FAIL rise_timeout: observed no ser_clk rise expected one within %0d clks", RISE_LIMIT);
        end else begin
            check("bit_gap", ticks_since_rise, gap);
        end
        rise_pending     = 1'b0;
        ticks_since_rise = 0;
    endtask

    task automatic pop_expected(output logic [7:0] word, output bit und);
        if (exp_q.size() > 0) begin
            word = exp_q.pop_front();
            und  = 1'b0;
        end else begin
            word = IDLE_WORD;
            und  = 1'b1;
        end
    endtask

    task automatic recv_slot(input logic [7:0] word, input bit und, input int nbits, input int first_gap);
        for (int b = 0; b < nbits; b++) begin
            wait_rise((b == 0) ? first_gap : 2 * CLK_DIV);
            check("ser_d", ser_d, word[7-b]);
            if (b == 0) begin
                check("ser_fs_load", ser_fs, exp_chan == 0);
                check("frame_start", frame_start, exp_chan == 0);
                check("underrun", underrun, und);
                check("cur_chan", cur_chan, exp_chan);
                check("fifo_level", fifo_level, exp_q.size());
                check("in_ready", in_ready, exp_q.size() < FIFO_DEPTH);
                if (exp_chan == 0) fs_cnt = 1;
            end else begin
                check("ser_fs_bit", ser_fs, 0);
                check("frame_start_bit", frame_start, 0);
                check("underrun_bit", underrun, 0);
                if (b == 1 && exp_chan == 0) check("fs_width", fs_cnt, 2 * CLK_DIV);
            end
        end
        if (nbits == WORD_W) exp_chan = (exp_chan + 1) % CHANNELS;
    endtask

    task automatic applyStimulus(input logic [7:0] d);
        in_data  = d;
        in_valid = 1'b1;
        check("push_ready", in_ready, exp_q.size() < FIFO_DEPTH);
        if (exp_q.size() < FIFO_DEPTH) exp_q.push_back(d);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic start_tx();
        enable           = 1'b1;
        ticks_since_rise = 0;
        rise_pending     = 1'b0;
        exp_chan         = 0;
    endtask

    task automatic checkOutput(input string tag);
        check({tag, "_ser_d"}, ser_d, 0);
        check({tag, "_ser_clk"}, ser_clk, 0);
        check({tag, "_ser_fs"}, ser_fs, 0);
        check({tag, "_frame_start"}, frame_start, 0);
        check({tag, "_underrun"}, underrun, 0);
        check({tag, "_cur_chan"}, cur_chan, 0);
    endtask

    initial begin
        logic [7:0] w;
        bit         u;

        reset            = 1'b0;
        enable           = 1'b0;
        in_valid         = 1'b0;
        in_data          = 8'h00;
        prev_clk         = 1'b0;
        rise_pending     = 1'b0;
        ticks_since_rise = 0;
        fs_cnt           = 0;
        exp_chan         = 0;

        // Reset state
        repeat (3) tick();
        checkOutput("reset");
        check("reset_in_ready", in_ready, 1);
        check("reset_fifo_level", fifo_level, 0);
        reset = 1'b1;
        repeat (8) begin
            tick();
            check("idle_no_toggle", ser_clk, 0);
        end

        // Two words, then run into empty-FIFO idle slots
        applyStimulus(8'hA5);
        applyStimulus(8'h3C);
        check("two_words_level", fifo_level, 2);
        start_tx();
        pop_expected(w, u);
        recv_slot(w, u, WORD_W, CLK_DIV);
        pop_expected(w, u);
        recv_slot(w, u, WORD_W, 2 * CLK_DIV);
        for (int s = 0; s < 4; s++) begin
            pop_expected(w, u);
            recv_slot(w, u, WORD_W, 2 * CLK_DIV);
        end

        // Push in the same cycle as a word load on an empty FIFO
        pop_expected(w, u);
        repeat (2 * CLK_DIV - 1) tick();
        in_data  = 8'h69;
        in_valid = 1'b1;
        check("race_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        exp_q.push_back(8'h69);
        recv_slot(w, u, WORD_W, 2 * CLK_DIV);
        pop_expected(w, u);
        recv_slot(w, u, WORD_W, 2 * CLK_DIV);

        enable = 1'b0;
        tick();
        checkOutput("disabled");

        // Fill the FIFO while disabled; extra pushes are refused
        for (int k = 0; k < 6; k++) begin
            applyStimulus(8'(8'h11 * (k + 1)));
        end
        check("full_level", fifo_level, 4);
        check("full_in_ready", in_ready, 0);

        // Run, abandon slot 1 after bit 3, restart at slot 0
        start_tx();
        pop_expected(w, u);
        recv_slot(w, u, WORD_W, CLK_DIV);
        pop_expected(w, u);
        recv_slot(w, u, 4, 2 * CLK_DIV);
        enable = 1'b0;
        tick();
        checkOutput("drop");
        check("drop_fifo_level", fifo_level, exp_q.size());
        repeat (5) tick();
        start_tx();
        pop_expected(w, u);
        recv_slot(w, u, 3, CLK_DIV);

        // Asynchronous reset mid-frame empties the FIFO
        reset  = 1'b0;
        enable = 1'b0;
        #1;
        checkOutput("async_reset");
        check("async_reset_level", fifo_level, 0);
        check("async_reset_ready", in_ready, 1);
        exp_q.delete();
        tick();
        reset = 1'b1;
        tick();
        start_tx();
        pop_expected(w, u);
        recv_slot(w, u, WORD_W, CLK_DIV);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
